// File: rtl/ifetch_arbiter.sv
// Round-robin arbiter sharing one synchronous instruction memory between N_CORES cores.
// Grants one fetch per cycle, routes the returned word back one cycle later, tracks endop.
module ifetch_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 17,
    parameter int OPC_W   = 5,
    parameter logic [OPC_W-1:0] ENDOP_OPC = 5'd31
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_start,
    input  logic [N_CORES-1:0]          i_core_req,
    input  logic [N_CORES*ADDR_W-1:0]   i_core_addr,
    output logic [N_CORES-1:0]          o_core_gnt,
    output logic [N_CORES-1:0]          o_core_instr_valid,
    output logic [INSTR_W-1:0]          o_core_instr,
    output logic [ADDR_W-1:0]           o_mem_addr,
    input  logic [INSTR_W-1:0]          i_mem_instr,
    output logic [N_CORES-1:0]          o_core_done,
    output logic                        o_all_done
);

    localparam int PTR_W = $clog2(N_CORES);

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [N_CORES-1:0] r_inflight;
    logic [N_CORES-1:0] r_core_done;

    logic [N_CORES-1:0] w_elig;
    logic [N_CORES-1:0] w_gnt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic               w_any;
    logic               w_endop;

    assign w_elig = i_core_req & ~r_core_done;

    // Scan from the pointer with wrap-around; first eligible core wins.
    always_comb begin
        int idx;
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= N_CORES) idx = idx - N_CORES;
            if (!w_any && w_elig[idx]) begin
                w_any      = 1'b1;
                w_gnt[idx] = 1'b1;
                w_gnt_idx  = idx[PTR_W-1:0];
            end
        end
    end

    assign o_core_gnt = w_gnt;
    assign o_mem_addr = w_any ? i_core_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W] : '0;

    assign w_endop = (|r_inflight) && (i_mem_instr[INSTR_W-1 -: OPC_W] == ENDOP_OPC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_inflight  <= '0;
            r_core_done <= '0;
        end else begin
            r_inflight <= w_gnt;
            // start wins over both the pointer advance and a same-cycle endop
            if (i_start) begin
                r_rr_ptr    <= '0;
                r_core_done <= '0;
            end else begin
                if (w_any) begin
                    r_rr_ptr <= (w_gnt_idx == PTR_W'(N_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
                end
                if (w_endop) begin
                    r_core_done <= r_core_done | r_inflight;
                end
            end
        end
    end

    assign o_core_instr_valid = r_inflight;
    assign o_core_instr       = (|r_inflight) ? i_mem_instr : '0;
    assign o_core_done        = r_core_done;
    assign o_all_done         = &r_core_done;

endmodule

// File: tb/tb_ifetch_arbiter.sv
// Self-checking bench for ifetch_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_ifetch_arbiter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  req;
    logic [47:0] addr;
    logic [3:0]  gnt;
    logic [3:0]  valid;
    logic [16:0] instr;
    logic [11:0] mem_addr;
    logic [16:0] mem_instr;
    logic [3:0]  done;
    logic        all_done;

    logic [16:0] ram [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          m_ptr;
    logic [3:0]  m_done;
    logic        m_inf_valid;
    int          m_inf_core;
    logic [16:0] m_inf_word;

    ifetch_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_start            (start),
        .i_core_req         (req),
        .i_core_addr        (addr),
        .o_core_gnt         (gnt),
        .o_core_instr_valid (valid),
        .o_core_instr       (instr),
        .o_mem_addr         (mem_addr),
        .i_mem_instr        (mem_instr),
        .o_core_done        (done),
        .o_all_done         (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_instr <= ram[mem_addr];

    function automatic int model_gnt();
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (req[idx] && !m_done[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_ptr       = 0;
        m_done      = '0;
        m_inf_valid = 1'b0;
        m_inf_core  = 0;
        m_inf_word  = '0;
    endtask

    task automatic set_addr(input int i, input int a);
        addr[i*12 +: 12] = 12'(a);
    endtask

    // Advance one clock edge, applying the model rules to the inputs seen at that edge.
    task automatic tick();
        int g;
        logic [16:0] w;
        g = model_gnt();
        w = (g >= 0) ? ram[addr[g*12 +: 12]] : '0;
        @(posedge clk);
        if (m_inf_valid && m_inf_word[16:12] == 5'd31) m_done[m_inf_core] = 1'b1;
        if (start) begin
            m_done = '0;
            m_ptr  = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % 4;
        end
        m_inf_valid = (g >= 0);
        m_inf_core  = (g >= 0) ? g : 0;
        m_inf_word  = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        req   = '0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req = 4'hF;
        start = 1'b0;
        for (int i = 0; i < 4; i++) set_addr(i, i + 1);
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (valid !== 4'b0 || instr !== 17'b0) begin
            n_fail++;
            $display("FAIL reset_out valid=%b instr=%h expected 0/0", valid, instr);
        end
        n_checks++;
        if (done !== 4'b0 || all_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done done=%b all=%b expected 0/0", done, all_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 4'b0001 || mem_addr !== 12'd1) begin
            n_fail++;
            $display("FAIL reset_first_gnt gnt=%b addr=%0d expected 0001/1", gnt, mem_addr);
        end
        tick();
    endtask

    task automatic test_all_req();
        logic [3:0]  exp_g;
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, (i + 1) * 10);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req = (c < 8) ? 4'hF : 4'h0;
            #1;
            exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
            n_checks++;
            if (gnt !== exp_g) begin
                n_fail++;
                $display("FAIL rr_gnt c=%0d gnt=%b expected %b", c, gnt, exp_g);
            end
            if (c > 0) begin
                n_checks++;
                if (valid !== 4'(1 << ((c - 1) % 4)) ||
                    instr !== ram[(((c - 1) % 4) + 1) * 10]) begin
                    n_fail++;
                    $display("FAIL rr_data c=%0d valid=%b instr=%h expected %b/%h", c, valid,
                             instr, 4'(1 << ((c - 1) % 4)), ram[(((c - 1) % 4) + 1) * 10]);
                end
            end
            tick();
        end
    endtask

    task automatic test_single_core();
        do_reset();
        for (int i = 0; i < 4; i++) set_addr(i, 200 + i);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req = (c < 3) ? 4'b0100 : 4'hF;
            set_addr(2, 5 + c);
            #1;
            if (c < 3) begin
                n_checks++;
                if (gnt !== 4'b0100 || mem_addr !== 12'(5 + c)) begin
                    n_fail++;
                    $display("FAIL single_gnt c=%0d gnt=%b addr=%0d expected 0100/%0d", c, gnt,
                             mem_addr, 5 + c);
                end
            end else begin
                n_checks++;
                if (gnt !== 4'b1000) begin
                    n_fail++;
                    $display("FAIL single_ptr gnt=%b expected 1000", gnt);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (valid !== 4'b0100 || instr !== ram[4 + c]) begin
                    n_fail++;
                    $display("FAIL single_data c=%0d valid=%b instr=%h expected 0100/%h", c,
                             valid, instr, ram[4 + c]);
                end
            end
            tick();
        end
    endtask

    task automatic test_endop();
        do_reset();
        @(negedge clk);
        req = 4'b0010;
        set_addr(1, 100);
        tick();
        @(negedge clk);
        req = 4'b0000;
        #1;
        n_checks++;
        if (valid !== 4'b0010 || instr !== 17'h1F000 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL endop_deliver valid=%b instr=%h done=%b expected 0010/1f000/0000",
                     valid, instr, done);
        end
        tick();
        @(negedge clk);
        req = 4'b0010;
        set_addr(1, 7);
        #1;
        n_checks++;
        if (done !== 4'b0010 || gnt !== 4'b0000) begin
            n_fail++;
            $display("FAIL endop_block done=%b gnt=%b expected 0010/0000", done, gnt);
        end
        tick();
        for (int i = 0; i < 4; i++) set_addr(i, 4000 + i);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req = 4'hF;
            #1;
            n_checks++;
            if (gnt !== ((model_gnt() >= 0) ? 4'(1 << model_gnt()) : 4'b0)) begin
                n_fail++;
                $display("FAIL endop_gnt c=%0d gnt=%b model_core=%0d", c, gnt, model_gnt());
            end
            tick();
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (done !== 4'hF || all_done !== 1'b1 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL all_done done=%b all=%b gnt=%b expected 1111/1/0000", done,
                     all_done, gnt);
        end
        tick();
    endtask

    task automatic test_start_endop();
        do_reset();
        @(negedge clk);
        req = 4'b1000;
        set_addr(3, 4001);
        tick();
        @(negedge clk);
        start = 1'b1;
        req   = 4'b0010;
        set_addr(1, 300);
        #1;
        n_checks++;
        if (valid !== 4'b1000 || instr !== ram[4001]) begin
            n_fail++;
            $display("FAIL start_deliver valid=%b instr=%h expected 1000/%h", valid, instr,
                     ram[4001]);
        end
        tick();
        @(negedge clk);
        start = 1'b0;
        req   = 4'hF;
        for (int i = 0; i < 4; i++) set_addr(i, 400 + i);
        #1;
        n_checks++;
        if (done !== 4'b0 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL start_clear done=%b gnt=%b expected 0000/0001", done, gnt);
        end
        n_checks++;
        if (valid !== 4'b0010 || instr !== ram[300]) begin
            n_fail++;
            $display("FAIL start_inflight valid=%b instr=%h expected 0010/%h", valid, instr,
                     ram[300]);
        end
        tick();
    endtask

    task automatic test_reset_midfetch();
        do_reset();
        @(negedge clk);
        req = 4'b0001;
        set_addr(0, 9);
        #1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL midrst_gnt gnt=%b expected 0001", gnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (valid !== 4'b0 || instr !== 17'b0 || done !== 4'b0) begin
            n_fail++;
            $display("FAIL midrst_out valid=%b instr=%h done=%b expected 0", valid, instr, done);
        end
        @(negedge clk);
        req   = 4'b0;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        #1;
        n_checks++;
        if (valid !== 4'b0 || instr !== 17'b0) begin
            n_fail++;
            $display("FAIL midrst_after valid=%b instr=%h expected 0/0", valid, instr);
        end
        tick();
    endtask

    task automatic test_random();
        logic [3:0]  e_gnt;
        logic [11:0] e_addr;
        int          g;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            req   = 4'($urandom);
            start = ($urandom_range(0, 24) == 0);
            for (int i = 0; i < 4; i++) begin
                set_addr(i, ($urandom_range(0, 7) == 0) ? 4000 + $urandom_range(0, 95)
                                                          : $urandom_range(0, 3999));
            end
            #1;
            g      = model_gnt();
            e_gnt  = (g >= 0) ? 4'(1 << g) : 4'b0;
            e_addr = (g >= 0) ? addr[g*12 +: 12] : 12'b0;
            n_checks++;
            if (gnt !== e_gnt || mem_addr !== e_addr) begin
                n_fail++;
                $display("FAIL rand_gnt c=%0d gnt=%b addr=%0d expected %b/%0d", c, gnt,
                         mem_addr, e_gnt, e_addr);
            end
            n_checks++;
            if (valid !== (m_inf_valid ? 4'(1 << m_inf_core) : 4'b0) ||
                instr !== (m_inf_valid ? m_inf_word : 17'b0)) begin
                n_fail++;
                $display("FAIL rand_data c=%0d valid=%b instr=%h expected core %0d v=%b w=%h",
                         c, valid, instr, m_inf_core, m_inf_valid, m_inf_word);
            end
            n_checks++;
            if (done !== m_done || all_done !== (&m_done)) begin
                n_fail++;
                $display("FAIL rand_done c=%0d done=%b all=%b expected %b", c, done, all_done,
                         m_done);
            end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        req   = '0;
        addr  = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = {5'($urandom_range(0, 30)), 12'($urandom)};
        end
        for (int i = 4000; i < 4096; i++) ram[i] = {5'd31, 12'($urandom)};
        ram[100] = 17'h1F000;
        model_clear();

        test_reset();
        test_all_req();
        test_single_core();
        test_endop();
        test_start_endop();
        test_reset_midfetch();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
